mips_mc_control: RTL
====================

Name: mips_mc_control

Overview:
- Multicycle control unit for the MIPSmulticycle datapath.
- Decodes the instruction register (IR) opcode and funct fields.
- Sequences fetch / decode / execute / memory / writeback as a Moore FSM.
- Drives every datapath mux select, register and memory enable, and the ALU operation code.
- Stalls on a unified-memory ready handshake and flags unsupported opcodes.

Parameters:
- USE_MEM_RDY, 1: 1 = memory states wait for MemRdy; 0 = MemRdy ignored, every memory state lasts 1 cycle.
- STATE_W, 4: width of the state register and the dbg_state port.

Ports:
- CK  in  1  clock; all state changes on the rising edge.
- CLR  in  1  synchronous active-high reset.
- Op  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- MemRdy  in  1  memory access complete this cycle.
- PCEn  out  1  PC load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR load enable.
- RegDst  out  1  write-register select: 1 = rd, 0 = rt.
- MemtoReg  out  1  write-data select: 1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = const 4, 10 = ext imm, 11 = ext imm << 2.
- ExtOp  out  1  immediate extension: 1 = sign, 0 = zero.
- PCSource  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUCtl  out  3  ALU operation: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- Illegal  out  1  sticky unsupported-opcode flag.
- dbg_state  out  STATE_W  current state.

Behaviour:
- Reset
  - CLR = 1 at a rising edge: state <= IDLE, Illegal <= 0.
  - Takes priority over every transition, including mid-instruction and mid-memory-wait.
  - In IDLE all outputs are 0 except ALUCtl = 010.
- States and transitions:
  - IDLE(0) -> FETCH.
  - FETCH(1): MemRead, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUCtl = add, PCSource = 00. IRWrite and PCEn pulse only in the cycle MemRdy = 1, then -> DECODE; otherwise hold FETCH.
  - DECODE(2): ALUSrcA = 0, ALUSrcB = 11, ExtOp = 1, ALUCtl = add (branch target into ALUOut).
    - lw, sw -> MEMADR
    - R-type -> REXEC
    - addi, andi, ori, slti -> IEXEC
    - beq -> BRANCH
    - j -> JUMP
    - any other opcode -> TRAP
  - MEMADR(3): ALUSrcA = 1, ALUSrcB = 10, ExtOp = 1, add. lw -> MEMRD, sw -> MEMWR.
  - MEMRD(4): MemRead, IorD = 1. Hold until MemRdy, then -> MEMWB.
  - MEMWB(5): RegWrite, RegDst = 0, MemtoReg = 1 -> FETCH.
  - MEMWR(6): MemWrite, IorD = 1. Hold until MemRdy, then -> FETCH. MemWrite stays asserted for the whole wait.
  - REXEC(7): ALUSrcA = 1, ALUSrcB = 00, ALUCtl from Funct -> RWB.
  - RWB(8): RegWrite, RegDst = 1, MemtoReg = 0 -> FETCH.
  - IEXEC(9): ALUSrcA = 1, ALUSrcB = 10.
    - ExtOp = 0 for andi/ori, 1 for addi/slti.
    - ALUCtl: addi = add, andi = and, ori = or, slti = slt.
    - -> IWB.
  - IWB(10): RegWrite, RegDst = 0, MemtoReg = 0 -> FETCH.
  - BRANCH(11): ALUSrcA = 1, ALUSrcB = 00, sub, PCSource = 01, PCEn = Zero -> FETCH.
  - JUMP(12): PCSource = 10, PCEn = 1 -> FETCH.
  - TRAP(13): Illegal <= 1; state holds until CLR. No write strobes asserted.
- Encodings:
  - Opcodes: R 0x00, j 0x02, beq 0x04, addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B.
  - Funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - Unknown funct in REXEC: ALUCtl = add, no trap.
- Rules:
  - Outputs are Moore-decoded from state, plus MemRdy gating (FETCH) and Zero gating (BRANCH).
  - Op and Funct are sampled from the IR, which is stable from DECODE onward.
  - MemRdy in non-memory states is ignored.
  - With USE_MEM_RDY = 0: FETCH, MEMRD and MEMWR each last exactly 1 cycle.
  - Latency with zero wait states: lw 5 cycles; sw, R-type, I-type 4 cycles; beq, j 3 cycles.
  - Each cycle of MemRdy = 0 adds one cycle to the memory state it occurs in.
  - Unused state encodings 14 and 15 -> IDLE on the next edge.

Decomposition:
- Package mips_mc_pkg holds:
  - state enumeration
  - opcode and funct constants
  - ALUCtl codes
  - ALUSrcB and PCSource codes
- Sub-module mips_alu_control: combinational map from (state class, Op, Funct) to ALUCtl and ExtOp; instantiated once.

Test Plan:
- CLR = 1 for 2 edges, then 0 -> first cycle IDLE with all outputs 0; next cycle FETCH with MemRead = 1.
- Op = 0x23 (lw), MemRdy = 1 always -> state sequence 1, 2, 3, 4, 5, 1. MemtoReg = 1 and RegWrite = 1 in state 5 only.
- Op = 0x2B (sw), MemRdy = 0 for 3 cycles in MEMWR -> MemWrite high for 4 consecutive cycles, then FETCH. RegWrite never asserted.
- Op = 0x00, Funct = 0x2A -> ALUCtl = 111 in REXEC. Op = 0x0D -> ExtOp = 0 and ALUCtl = 001 in IEXEC.
- Op = 0x04 with Zero = 0 -> PCEn = 0 in BRANCH. Op = 0x04 with Zero = 1 -> PCEn = 1, PCSource = 01. Op = 0x02 -> PCEn = 1, PCSource = 10.
- Op = 0x3F -> TRAP, Illegal = 1 held for 10 cycles. CLR asserted mid-MEMRD wait -> IDLE next edge, Illegal = 0.

Source files
------------

// File: rtl/mips_mc_control_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_e;

  // ALU usage class of a state; the ALU control sub-module refines it with Op/Funct.
  typedef enum logic [2:0] {
    CLS_ADD   = 3'd0,
    CLS_ADDR  = 3'd1,
    CLS_RTYPE = 3'd2,
    CLS_ITYPE = 3'd3,
    CLS_SUB   = 3'd4
  } alu_cls_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // Moore control word registered from the next state.
  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
  } ctl_t;

  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Control <-> datapath bundle: master is the control unit, slave the datapath.
interface mips_mc_control_if #(parameter int STATE_W = 4);
  logic [5:0]         Op;
  logic [5:0]         Funct;
  logic               Zero;
  logic               MemRdy;
  logic               PCEn;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic               ExtOp;
  logic [1:0]         PCSource;
  logic [2:0]         ALUCtl;
  logic               Illegal;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    input  Op, Funct, Zero, MemRdy,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ExtOp, PCSource, ALUCtl, Illegal, dbg_state
  );

  modport slave (
    output Op, Funct, Zero, MemRdy,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ExtOp, PCSource, ALUCtl, Illegal, dbg_state
  );
endinterface

// File: rtl/mips_mc_control_alu_control.sv
// Maps (state class, Op, Funct) to ALU operation and immediate extension mode.
module mips_alu_control
  import mips_mc_pkg::*;
(
  input  alu_cls_e   cls,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctl,
  output logic       ext_op
);

  always_comb begin
    alu_ctl = ALU_ADD;
    ext_op  = 1'b0;
    case (cls)
      CLS_ADDR: ext_op = 1'b1;
      CLS_SUB:  alu_ctl = ALU_SUB;
      CLS_RTYPE: begin
        // Unknown funct falls back to add rather than trapping.
        case (funct)
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_AND:  alu_ctl = ALU_AND;
          FN_OR:   alu_ctl = ALU_OR;
          FN_SLT:  alu_ctl = ALU_SLT;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      CLS_ITYPE: begin
        case (op)
          OP_ADDI: begin alu_ctl = ALU_ADD; ext_op = 1'b1; end
          OP_SLTI: begin alu_ctl = ALU_SLT; ext_op = 1'b1; end
          OP_ANDI: alu_ctl = ALU_AND;
          OP_ORI:  alu_ctl = ALU_OR;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: Moore outputs registered from the next state,
// with only the fetch-ready and branch-zero enables gated combinationally.
module mips_mc_control
  import mips_mc_pkg::*;
#(
  parameter int USE_MEM_RDY = 1,
  parameter int STATE_W     = 4
)(
  input logic              CK,
  input logic              CLR,
  mips_mc_control_if.master bus
);

  state_e     state_q, state_d;
  ctl_t       ctl_q, ctl_d;
  alu_cls_e   cls_d;
  logic [2:0] alu_ctl_q, alu_ctl_d;
  logic       ext_op_q, ext_op_d;
  logic       illegal_q, illegal_d;
  logic       mem_rdy;

  assign mem_rdy = (USE_MEM_RDY != 0) ? bus.MemRdy : 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        if ((bus.Op == OP_LW) || (bus.Op == OP_SW)) state_d = S_MEMADR;
        else if (bus.Op == OP_R)                    state_d = S_REXEC;
        else if (is_itype(bus.Op))                  state_d = S_IEXEC;
        else if (bus.Op == OP_BEQ)                  state_d = S_BRANCH;
        else if (bus.Op == OP_J)                    state_d = S_JUMP;
        else                                        state_d = S_TRAP;
      end
      S_MEMADR: state_d = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_REXEC:  state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control word for the state being entered, so outputs are glitch-free flops.
  always_comb begin
    ctl_d = '0;
    cls_d = CLS_ADD;
    case (state_d)
      S_FETCH: begin
        ctl_d.mem_read  = 1'b1;
        ctl_d.alu_src_b = SRCB_FOUR;
        ctl_d.pc_source = PCS_ALU;
      end
      S_DECODE: begin
        ctl_d.alu_src_b = SRCB_IMMSH;
        cls_d           = CLS_ADDR;
      end
      S_MEMADR: begin
        ctl_d.alu_src_a = 1'b1;
        ctl_d.alu_src_b = SRCB_IMM;
        cls_d           = CLS_ADDR;
      end
      S_MEMRD: begin
        ctl_d.mem_read = 1'b1;
        ctl_d.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctl_d.reg_write  = 1'b1;
        ctl_d.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctl_d.mem_write = 1'b1;
        ctl_d.iord      = 1'b1;
      end
      S_REXEC: begin
        ctl_d.alu_src_a = 1'b1;
        ctl_d.alu_src_b = SRCB_REG;
        cls_d           = CLS_RTYPE;
      end
      S_RWB: begin
        ctl_d.reg_write = 1'b1;
        ctl_d.reg_dst   = 1'b1;
      end
      S_IEXEC: begin
        ctl_d.alu_src_a = 1'b1;
        ctl_d.alu_src_b = SRCB_IMM;
        cls_d           = CLS_ITYPE;
      end
      S_IWB: ctl_d.reg_write = 1'b1;
      S_BRANCH: begin
        ctl_d.alu_src_a = 1'b1;
        ctl_d.alu_src_b = SRCB_REG;
        ctl_d.pc_source = PCS_ALUOUT;
        cls_d           = CLS_SUB;
      end
      S_JUMP: begin
        ctl_d.pc_source = PCS_JUMP;
        ctl_d.pcen      = 1'b1;
      end
      default: ;
    endcase
  end

  mips_alu_control u_alu_ctl (
    .cls     (cls_d),
    .op      (bus.Op),
    .funct   (bus.Funct),
    .alu_ctl (alu_ctl_d),
    .ext_op  (ext_op_d)
  );

  assign illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge CK) begin
    if (CLR) begin
      state_q   <= S_IDLE;
      ctl_q     <= '0;
      alu_ctl_q <= ALU_ADD;
      ext_op_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctl_q     <= ctl_d;
      alu_ctl_q <= alu_ctl_d;
      ext_op_q  <= ext_op_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.IRWrite   = (state_q == S_FETCH) && mem_rdy;
  assign bus.PCEn      = ctl_q.pcen | ((state_q == S_FETCH) && mem_rdy)
                       | ((state_q == S_BRANCH) && bus.Zero);
  assign bus.IorD      = ctl_q.iord;
  assign bus.MemRead   = ctl_q.mem_read;
  assign bus.MemWrite  = ctl_q.mem_write;
  assign bus.RegDst    = ctl_q.reg_dst;
  assign bus.MemtoReg  = ctl_q.mem_to_reg;
  assign bus.RegWrite  = ctl_q.reg_write;
  assign bus.ALUSrcA   = ctl_q.alu_src_a;
  assign bus.ALUSrcB   = ctl_q.alu_src_b;
  assign bus.PCSource  = ctl_q.pc_source;
  assign bus.ALUCtl    = alu_ctl_q;
  assign bus.ExtOp     = ext_op_q;
  assign bus.Illegal   = illegal_q;
  assign bus.dbg_state = STATE_W'(state_q);

endmodule
